// File: rtl/fpga_cmd_spi_tx.sv
// fpga_cmd_spi_tx: SPI master shifting 16-bit FPGA command words out MSB first
// on spck/mosi/ncs. The rising edge of ncs commits the word in the receiver.
// Optional feature macro: SPI_TX_MISO_CAPTURE_EN (captures miso into rx_word).
//
// Handshake: a word is accepted on any pck0 edge where cmd_valid and cmd_ready
// are both high; cmd_ready is a register that is high only in IDLE, so there is
// no combinational path from cmd_valid to cmd_ready.
module fpga_cmd_spi_tx #(
    parameter int CLK_DIV = 4,  // pck0 cycles per spck half-period, 1..255
    parameter int NCS_GAP = 8   // minimum ncs-high cycles between words, 1..255
) (
    input  logic        pck0,
    input  logic        nreset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_word,
    output logic        spck,
    output logic        mosi,
    output logic        ncs,
    input  logic        miso,
    output logic        busy,
    output logic        done,
    output logic [15:0] rx_word
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        GAP   = 3'd4
    } state_e;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_RELOAD = 8'(NCS_GAP - 1);

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] shreg_q, shreg_d;
    logic        spck_q, spck_d;
    logic        mosi_q, mosi_d;
    logic        ncs_q, ncs_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;

`ifdef SPI_TX_MISO_CAPTURE_EN
    logic [15:0] rxsh_q, rxsh_d;
    logic [15:0] rx_word_q, rx_word_d;
`else
    logic        unused_miso;
    assign unused_miso = miso;
`endif

    // Next-state logic; outputs are decoded from the next state so they can be registered.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
`ifdef SPI_TX_MISO_CAPTURE_EN
        rxsh_d    = rxsh_q;
        rx_word_d = rx_word_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = SETUP;
                    div_d   = DIV_RELOAD;
                    bit_d   = 4'd15;
                    shreg_d = cmd_word;
`ifdef SPI_TX_MISO_CAPTURE_EN
                    rxsh_d  = 16'h0000;
`endif
                end
            end
            SETUP, LOW: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else if (state_q == LOW && bit_q == 4'd0) begin
                    // Final hold of the last bit is over: release ncs.
                    state_d = GAP;
                    div_d   = GAP_RELOAD;
`ifdef SPI_TX_MISO_CAPTURE_EN
                    rx_word_d = rxsh_q;
`endif
                end else begin
                    state_d = HIGH;
                    div_d   = DIV_RELOAD;
                    if (state_q == LOW) begin
                        bit_d = bit_q - 4'd1;
                    end
`ifdef SPI_TX_MISO_CAPTURE_EN
                    // spck rises at this edge: sample the return bit.
                    rxsh_d = {rxsh_q[14:0], miso};
`endif
                end
            end
            HIGH: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else begin
                    state_d = LOW;
                    div_d   = DIV_RELOAD;
                    shreg_d = {shreg_q[14:0], 1'b0};
                end
            end
            GAP: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        spck_d  = (state_d == HIGH);
        ncs_d   = !(state_d == SETUP || state_d == HIGH || state_d == LOW);
        mosi_d  = ncs_d ? 1'b0 : shreg_d[15];
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        done_d  = (state_d == GAP) && (state_q != GAP);
    end

    // State, counters and registered outputs; reset forces idle outputs at once.
    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            bit_q   <= 4'd15;
            shreg_q <= 16'h0000;
            spck_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            spck_q  <= spck_d;
            mosi_q  <= mosi_d;
            ncs_q   <= ncs_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

`ifdef SPI_TX_MISO_CAPTURE_EN
    // Return-data shift register and the word presented at done.
    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            rxsh_q    <= 16'h0000;
            rx_word_q <= 16'h0000;
        end else begin
            rxsh_q    <= rxsh_d;
            rx_word_q <= rx_word_d;
        end
    end
    assign rx_word = rx_word_q;
`else
    assign rx_word = 16'h0000;
`endif

    assign cmd_ready = ready_q;
    assign spck      = spck_q;
    assign mosi      = mosi_q;
    assign ncs       = ncs_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fpga_cmd_spi_tx.sv
// Bench for fpga_cmd_spi_tx: two instances (CLK_DIV=4/NCS_GAP=8 and CLK_DIV=1/NCS_GAP=3).
// Drivers push expected words; a monitor acting as the SPI receiver reassembles
// each frame at ncs rise and compares against the expected queue.
module tb_fpga_cmd_spi_tx;

  localparam int CDIV [2] = '{4, 1};
  localparam int GAPS [2] = '{8, 3};

  // clock / reset
  logic pck0 = 1'b0;
  logic nreset = 1'b0;
  always #5 pck0 = ~pck0;

  logic        cmd_valid_a [2];
  logic [15:0] cmd_word_a  [2];
  logic        miso_a      [2];
  logic        cmd_ready_a [2];
  logic        spck_a      [2];
  logic        mosi_a      [2];
  logic        ncs_a       [2];
  logic        busy_a      [2];
  logic        done_a      [2];
  logic [15:0] rx_word_a   [2];

  fpga_cmd_spi_tx #(.CLK_DIV(4), .NCS_GAP(8)) dut0 (
    .pck0(pck0), .nreset(nreset), .cmd_valid(cmd_valid_a[0]), .cmd_ready(cmd_ready_a[0]),
    .cmd_word(cmd_word_a[0]), .spck(spck_a[0]), .mosi(mosi_a[0]), .ncs(ncs_a[0]),
    .miso(miso_a[0]), .busy(busy_a[0]), .done(done_a[0]), .rx_word(rx_word_a[0])
  );

  fpga_cmd_spi_tx #(.CLK_DIV(1), .NCS_GAP(3)) dut1 (
    .pck0(pck0), .nreset(nreset), .cmd_valid(cmd_valid_a[1]), .cmd_ready(cmd_ready_a[1]),
    .cmd_word(cmd_word_a[1]), .spck(spck_a[1]), .mosi(mosi_a[1]), .ncs(ncs_a[1]),
    .miso(miso_a[1]), .busy(busy_a[1]), .done(done_a[1]), .rx_word(rx_word_a[1])
  );

  // scoreboard
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // receiver model / monitor state
  logic        prev_spck [2];
  logic        prev_ncs  [2];
  logic        in_frame  [2];
  logic        seen_frame[2];
  logic        after_end [2];
  logic        mosi_rise [2];
  logic        first_pat [2];
  logic        b2b_mode  [2];
  logic [15:0] sh        [2];
  logic [15:0] pat       [2];
  logic [7:0]  conf_rx   [2];
  logic [7:0]  conf_exp  [2];
  int          rises     [2];
  int          low_cnt   [2];
  int          high_cnt  [2];
  int          ready_cnt [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      cmd_valid_a[i] = 1'b0; cmd_word_a[i] = 16'h0000; miso_a[i] = 1'b0;
      prev_spck[i] = 1'b0; prev_ncs[i] = 1'b1; in_frame[i] = 1'b0; seen_frame[i] = 1'b0;
      after_end[i] = 1'b0; mosi_rise[i] = 1'b0; first_pat[i] = 1'b1; b2b_mode[i] = 1'b0;
      sh[i] = 16'h0; pat[i] = 16'h0; conf_rx[i] = 8'h00; conf_exp[i] = 8'h00;
      rises[i] = 0; low_cnt[i] = 0; high_cnt[i] = 0; ready_cnt[i] = -1;
    end
  end

  // monitor: samples on the falling edge, reassembles frames, drives miso
  always @(negedge pck0) begin
    if (!nreset) begin
      for (int i = 0; i < 2; i++) begin
        in_frame[i] = 1'b0; prev_spck[i] = 1'b0; prev_ncs[i] = 1'b1; seen_frame[i] = 1'b0;
        after_end[i] = 1'b0; ready_cnt[i] = -1; miso_a[i] = 1'b0; rises[i] = 0;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic s, n, m, frame_end;
        logic [15:0] w, exp_rx;
        s = spck_a[i]; n = ncs_a[i]; m = mosi_a[i];
        frame_end = 1'b0;
        if (!n && prev_ncs[i]) begin
          if (b2b_mode[i] && seen_frame[i])
            check($sformatf("inst%0d ncs_gap_cycles", i), high_cnt[i], GAPS[i] + 1);
          in_frame[i] = 1'b1; sh[i] = 16'h0; rises[i] = 0; low_cnt[i] = 0;
          pat[i] = first_pat[i] ? 16'hA5C3 : 16'($urandom);
          first_pat[i] = 1'b0;
        end
        if (!n) low_cnt[i]++;
        else high_cnt[i]++;
        if (in_frame[i] && !n) begin
          if (s && !prev_spck[i]) begin
            sh[i] = {sh[i][14:0], m};
            rises[i]++;
            mosi_rise[i] = m;
          end else if (s && prev_spck[i]) begin
            check($sformatf("inst%0d mosi_stable_while_spck_high", i), m, mosi_rise[i]);
          end
        end
        miso_a[i] = (rises[i] < 16) ? pat[i][4'(15 - rises[i])] : 1'b0;
        if (n && !prev_ncs[i] && in_frame[i]) begin
          frame_end = 1'b1;
          in_frame[i] = 1'b0; seen_frame[i] = 1'b1; after_end[i] = 1'b1;
          high_cnt[i] = 1; ready_cnt[i] = 0;
          check($sformatf("inst%0d done_at_ncs_rise", i), done_a[i], 1'b1);
          check($sformatf("inst%0d busy_in_gap", i), busy_a[i], 1'b1);
          check($sformatf("inst%0d spck_rises", i), rises[i], 16);
          check($sformatf("inst%0d ncs_low_cycles", i), low_cnt[i], 33 * CDIV[i]);
`ifdef SPI_TX_MISO_CAPTURE_EN
          exp_rx = pat[i];
`else
          exp_rx = 16'h0000;
`endif
          check($sformatf("inst%0d rx_word", i), rx_word_a[i], exp_rx);
          if (qsize(i) == 0) begin
            check($sformatf("inst%0d unexpected_frame", i), sh[i], 32'hFFFF_FFFF);
          end else begin
            w = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("inst%0d frame_word", i), sh[i], w);
            if (w[15:12] == 4'h1) conf_exp[i] = w[7:0];
            if (sh[i][15:12] == 4'h1 && rises[i] == 16) conf_rx[i] = sh[i][7:0];
            check($sformatf("inst%0d conf_word", i), conf_rx[i], conf_exp[i]);
          end
        end else if (after_end[i]) begin
          check($sformatf("inst%0d done_one_cycle", i), done_a[i], 1'b0);
          after_end[i] = 1'b0;
        end
        if (ready_cnt[i] >= 0 && !frame_end) begin
          ready_cnt[i]++;
          if (cmd_ready_a[i]) begin
            check($sformatf("inst%0d ready_return_cycles", i), ready_cnt[i], GAPS[i]);
            ready_cnt[i] = -1;
          end
        end
        prev_spck[i] = s;
        prev_ncs[i] = n;
      end
    end
  end

  // driver tasks
  task automatic wait_ready(input int i, output logic ok);
    int n = 0;
    @(negedge pck0);
    while (!cmd_ready_a[i] && n < 3000) begin
      @(negedge pck0);
      n++;
    end
    ok = cmd_ready_a[i];
    if (!ok) check($sformatf("inst%0d wait_ready_timeout", i), 0, 1);
  endtask

  task automatic push_exp(input int i, input logic [15:0] w);
    if (i == 0) exp_q0.push_back(w);
    else exp_q1.push_back(w);
  endtask

  task automatic send(input int i, input logic [15:0] w);
    logic ok;
    wait_ready(i, ok);
    if (ok) begin
      cmd_valid_a[i] = 1'b1;
      cmd_word_a[i] = w;
      push_exp(i, w);
      @(posedge pck0);
      #1;
      cmd_valid_a[i] = 1'b0;
      cmd_word_a[i] = 16'($urandom);
    end
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    @(negedge pck0);
    while ((!cmd_ready_a[i] || qsize(i) != 0) && n < 5000) begin
      @(negedge pck0);
      n++;
    end
    if (n >= 5000) check($sformatf("inst%0d wait_idle_timeout", i), 0, 1);
  endtask

  task automatic send_pair(input int i, input logic [15:0] a, input logic [15:0] b);
    logic ok;
    int n = 0;
    wait_ready(i, ok);
    if (ok) begin
      cmd_valid_a[i] = 1'b1;
      cmd_word_a[i] = a;
      push_exp(i, a);
      @(posedge pck0);
      #1;
      cmd_word_a[i] = b;
      push_exp(i, b);
      check($sformatf("inst%0d ready_low_after_accept", i), cmd_ready_a[i], 1'b0);
      while (ncs_a[i] == 1'b0 || n == 0) begin
        @(negedge pck0);
        n++;
        if (n > 3000) break;
      end
      b2b_mode[i] = 1'b1;
      wait_ready(i, ok);
      @(posedge pck0);
      #1;
      cmd_valid_a[i] = 1'b0;
      wait_idle(i);
      b2b_mode[i] = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input int i, input string tag);
    check($sformatf("inst%0d %s cmd_ready", i, tag), cmd_ready_a[i], 1'b1);
    check($sformatf("inst%0d %s spck", i, tag), spck_a[i], 1'b0);
    check($sformatf("inst%0d %s mosi", i, tag), mosi_a[i], 1'b0);
    check($sformatf("inst%0d %s ncs", i, tag), ncs_a[i], 1'b1);
    check($sformatf("inst%0d %s busy", i, tag), busy_a[i], 1'b0);
    check($sformatf("inst%0d %s done", i, tag), done_a[i], 1'b0);
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    int n;
    nreset = 1'b0;
    repeat (3) @(negedge pck0);
    for (int i = 0; i < 2; i++) begin
      check_idle_outputs(i, "reset");
      check($sformatf("inst%0d reset rx_word", i), rx_word_a[i], 16'h0000);
    end
    nreset = 1'b1;

    // directed frames on the CLK_DIV=4 instance
    send(0, 16'h1055);
    wait_idle(0);
    check("inst0 conf_after_1055", conf_rx[0], 8'h55);
    send(0, 16'h2ABC);
    wait_idle(0);
    check("inst0 conf_after_2ABC", conf_rx[0], 8'h55);

    // back-to-back with cmd_valid held
    send_pair(0, 16'h1A0F, 16'h3C33);

    // randomized frames with random idle spacing
    for (int k = 0; k < 10; k++) begin
      send(0, 16'($urandom));
      repeat ($urandom_range(0, 40)) @(negedge pck0);
    end
    wait_idle(0);

    // reset in the middle of a word, at bit 7
    send(0, 16'h3C5A);
    n = 0;
    while (rises[0] < 8 && n < 2000) begin
      @(negedge pck0);
      n++;
    end
    check("inst0 reached_bit7", (rises[0] >= 8), 1'b1);
    #2;
    nreset = 1'b0;
    #1;
    check_idle_outputs(0, "async_reset");
    repeat (2) @(negedge pck0);
    nreset = 1'b1;
    @(negedge pck0);
    check("inst0 ready_after_reset", cmd_ready_a[0], 1'b1);
    send(0, 16'h10AA);
    wait_idle(0);
    check("inst0 conf_after_reset_resend", conf_rx[0], 8'hAA);

    // CLK_DIV=1 instance
    send(1, 16'h1055);
    wait_idle(1);
    send_pair(1, 16'h8001, 16'h7FFE);
    for (int k = 0; k < 8; k++) begin
      send(1, 16'($urandom));
      repeat ($urandom_range(0, 6)) @(negedge pck0);
    end
    wait_idle(1);

    repeat (5) @(negedge pck0);
    check("inst0 queue_empty", exp_q0.size(), 0);
    check("inst1 queue_empty", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
